// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_addsub_pkg
//  Description : Shared helpers for the pipelined adder/subtractor: derived
//                segment width and parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_addsub_pkg;

  // Bits handled by each pipeline segment.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

  // Legal when every segment gets the same non-zero number of bits.
  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_stage.sv
`default_nettype none
// ============================================================================
//  Module      : adder_stage
//  Description : One CHUNK-bit segment of the pipelined carry chain. Adds the
//                operand chunks plus carry-in and registers sum and carry-out
//                when enabled.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_en            - load enable (pipeline advance)
//                i_a, i_b, i_cin - operand chunks and carry-in
//                o_sum, o_cout   - registered chunk sum and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_stage #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0]   w_total;
  logic [CHUNK-1:0] r_sum;
  logic             r_cout;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_sum  <= w_total[CHUNK-1:0];
      r_cout <= w_total[CHUNK];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_addsub
//  Description : Pipelined two's-complement adder/subtractor with valid/ready
//                handshakes. The carry chain is cut into STAGES registered
//                segments; upper operand chunks are skewed forward and lower
//                result chunks are delayed so the whole result emerges at once.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                in_valid, in_ready    - operand handshake (in_ready is
//                                        combinational from out_ready)
//                a, b, c_in, sub       - operands, carry/borrow-in, mode
//                out_valid, out_ready  - result handshake
//                sum, c_out, ovf       - result, raw carry-out, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  logic              w_advance;
  logic [STAGES-1:0] r_v;
  logic              r_sa;
  logic              r_sb;

  // Per-stage views, element k belongs to the token currently entering or
  // sitting in stage k. Operand views hold chunks k..STAGES-1 right-aligned;
  // low views hold the already-finished result chunks 0..k-1.
  logic [WIDTH-1:0]  w_skew_a [STAGES];
  logic [WIDTH-1:0]  w_skew_b [STAGES];
  logic [WIDTH-1:0]  w_low    [STAGES];
  logic [CHUNK-1:0]  w_sum_q  [STAGES];
  logic [STAGES-1:0] w_cout_q;

  // Subtraction is a + ~b + ~c_in, so a borrow-in removes the implicit +1.
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub ? ~c_in : c_in;

  // The whole pipe moves together; a full last stage with no taker freezes it.
  assign w_advance = !r_v[STAGES-1] || out_ready;
  assign in_ready  = rst || w_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else if (w_advance) begin
      r_v <= STAGES'({r_v, in_valid});
    end
  end

  assign w_skew_a[0] = a;
  assign w_skew_b[0] = w_b_eff;
  assign w_low[0]    = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic w_cin;

    if (k == 0) begin : g_cin_first
      assign w_cin = w_c0;
    end else begin : g_cin_chain
      assign w_cin = w_cout_q[k-1];
    end

    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_advance),
      .i_a    (w_skew_a[k][CHUNK-1:0]),
      .i_b    (w_skew_b[k][CHUNK-1:0]),
      .i_cin  (w_cin),
      .o_sum  (w_sum_q[k]),
      .o_cout (w_cout_q[k])
    );

    if (k < STAGES-1) begin : g_skew
      localparam int REM = WIDTH - (k + 1) * CHUNK;
      localparam int LOW = (k + 1) * CHUNK;

      logic [REM-1:0] r_a_up;
      logic [REM-1:0] r_b_up;
      logic [LOW-1:0] r_low;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_up <= '0;
          r_b_up <= '0;
          r_low  <= '0;
        end else if (w_advance) begin
          r_a_up <= w_skew_a[k][CHUNK +: REM];
          r_b_up <= w_skew_b[k][CHUNK +: REM];
          // Append this stage's finished chunk above the earlier ones.
          r_low  <= LOW'(w_low[k] | (WIDTH'(w_sum_q[k]) << (k * CHUNK)));
        end
      end

      assign w_skew_a[k+1] = WIDTH'(r_a_up);
      assign w_skew_b[k+1] = WIDTH'(r_b_up);
      assign w_low[k+1]    = WIDTH'(r_low);
    end
  end

  // Operand sign bits travel with the top chunk into the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (w_advance) begin
      r_sa <= w_skew_a[STAGES-1][CHUNK-1];
      r_sb <= w_skew_b[STAGES-1][CHUNK-1];
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = w_low[STAGES-1] |
                     (WIDTH'(w_sum_q[STAGES-1]) << ((STAGES - 1) * CHUNK));
  assign c_out     = w_cout_q[STAGES-1];
  assign ovf       = (r_sa == r_sb) && (sum[WIDTH-1] != r_sa);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_addsub
//  Description : Self-checking bench for pipelined_addsub (32/4 and 8/1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, sum;

  logic        in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8;
  logic        c_out8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int          errors = 0;
  int          checks = 0;
  int          tnow   = 0;
  int          pushes = 0;
  exp_t        q[$];
  bit          hv = 1'b0;
  logic [31:0] hs;
  logic        hc, ho;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input bit lat);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.t = 0; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ic, input logic is);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = is ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {32'd0, (is ? ~ic : ic)};
    return mk(full[31:0], full[32], (ia[31] == bb[31]) && (full[31] != ia[31]), 1'b0);
  endfunction

  // One cycle: drive at the falling edge, check what the coming rising edge
  // will transfer, then move to the next falling edge.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ic, input logic is, input logic ordy, input exp_t e);
    exp_t g;
    exp_t ne;
    ne = e;
    in_valid = iv; a = ia; b = ib; c_in = ic; sub = is; out_ready = ordy;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rst || !(out_valid && !out_ready)});
    if (rst) begin
      q.delete();
      hv = 1'b0;
    end else begin
      if (hv) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_sum",   {32'd0, sum},       {32'd0, hs});
        chk("stall_cout",  {63'd0, c_out},     {63'd0, hc});
        chk("stall_ovf",   {63'd0, ovf},       {63'd0, ho});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          g = q.pop_front();
          chk("sum",  {32'd0, sum},   {32'd0, g.s});
          chk("cout", {63'd0, c_out}, {63'd0, g.c});
          chk("ovf",  {63'd0, ovf},   {63'd0, g.o});
          if (g.lat) chk("latency", 64'(tnow - g.t), 64'd4);
        end
      end
      hv = out_valid && !out_ready;
      hs = sum; hc = c_out; ho = ovf;
      if (iv && in_ready) begin
        ne.t = tnow;
        q.push_back(ne);
        pushes++;
      end
    end
    tnow++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, mk(32'd0, 1'b0, 1'b0, 1'b0));
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs, riv, rord;
    int          goal, n;
    logic [7:0]  pa, pb, bb8;
    logic [8:0]  full8;
    logic [7:0]  es8;
    logic        ec8, eo8;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},   64'd1);
    chk("rst_out_valid", {63'd0, out_valid},  64'd0);
    chk("rst_sum",       {32'd0, sum},        64'd0);
    chk("rst_valid8",    {63'd0, out_valid8}, 64'd0);
    rst = 1'b0;

    // Directed cases, full throughput, latency checked.
    step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    step(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1));
    step(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0, 1'b1));
    step(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b1));
    step(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1));
    step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h0001_0000, 1'b0, 1'b0, 1'b1));
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1));
    drain();

    // Random stream with random backpressure and bubbles.
    goal = pushes + 100;
    n = 0;
    while (pushes < goal && n < 2000) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      riv  = ($urandom_range(0, 9) != 0);
      rord = ($urandom_range(0, 2) != 0);
      step(riv, ra, rb, rc, rs, rord, model(ra, rb, rc, rs));
      n++;
    end
    chk("stream_count", 64'(pushes >= goal), 64'd1);
    drain();

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      step(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b0));
    end
    rst = 1'b1;
    step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, mk(32'd2, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_sum",   {32'd0, sum},       64'd0);
    chk("post_rst_cout",  {63'd0, c_out},     64'd0);
    chk("post_rst_ovf",   {63'd0, ovf},       64'd0);
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, mk(32'h2345_6789, 1'b0, 1'b0, 1'b1));
    drain();

    // Single-stage 8-bit configuration: result one cycle after acceptance.
    in_valid8 = 1'b1;
    es8 = '0; ec8 = 1'b0; eo8 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin
        chk("w8_valid", {63'd0, out_valid8}, 64'd1);
        chk("w8_sum",   {56'd0, sum8},       {56'd0, es8});
        chk("w8_cout",  {63'd0, c_out8},     {63'd0, ec8});
        chk("w8_ovf",   {63'd0, ovf8},       {63'd0, eo8});
      end
      pa = 8'($urandom); pb = 8'($urandom);
      if (i == 0) begin pa = 8'h7F; pb = 8'h01; end
      if (i == 1) begin pa = 8'hFF; pb = 8'h00; end
      a8 = pa; b8 = pb;
      c_in8 = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      sub8  = (i < 2)  ? 1'b0 : 1'($urandom_range(0, 1));
      bb8   = sub8 ? ~pb : pb;
      full8 = {1'b0, pa} + {1'b0, bb8} + {8'd0, (sub8 ? ~c_in8 : c_in8)};
      es8 = full8[7:0];
      ec8 = full8[8];
      eo8 = (pa[7] == bb8[7]) && (full8[7] != pa[7]);
      @(negedge clk);
    end
    in_valid8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
